// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, controller state and width definitions for seq_alu
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Base ops occupy 0-11; the M extension sits at 16-23 so op[4:3]==2'b10 marks it.
    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_PASSB  = 5'd10,
        OP_ADDB   = 5'd11,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_t;

    function automatic logic is_muldiv(input alu_op_t op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic is_div(input alu_op_t op);
        return (op[4:3] == 2'b10) && op[2];
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative shift-add multiplier and restoring divider on operand magnitudes
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    alu_op_t             op_q;
    logic [XLEN-1:0]     opnd;
    logic [XLEN-1:0]     hi;
    logic [XLEN-1:0]     lo;
    logic                neg_res;
    logic                neg_rem;
    logic [CNT_W-1:0]    cnt;

    logic                a_signed;
    logic                b_signed;
    logic                sa;
    logic                sb;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [XLEN-1:0]     hi_n;
    logic [XLEN-1:0]     lo_n;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN+1:0]     div_diff;
    logic [2*XLEN-1:0]   prod;
    logic [2*XLEN-1:0]   prod_s;

    assign a_signed = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_signed = op inside {OP_MULH, OP_DIV, OP_REM};
    assign sa       = a_signed & a[XLEN-1];
    assign sb       = b_signed & b[XLEN-1];
    assign mag_a    = sa ? -a : a;
    assign mag_b    = sb ? -b : b;

    // One iteration: hi:lo is the product/shifted multiplier, or remainder:quotient.
    always_comb begin
        mul_sum   = '0;
        div_shift = '0;
        div_diff  = '0;
        hi_n      = hi;
        lo_n      = lo;
        if (is_div(op_q)) begin
            div_shift = {hi, lo[XLEN-1]};
            div_diff  = {1'b0, div_shift} - {2'b00, opnd};
            if (div_diff[XLEN+1]) begin
                hi_n = div_shift[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b0};
            end else begin
                hi_n = div_diff[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b1};
            end
        end else begin
            mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
            hi_n    = mul_sum[XLEN:1];
            lo_n    = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Sign correction is applied to the values produced by the final iteration.
    always_comb begin
        prod   = {hi_n, lo_n};
        prod_s = neg_res ? -prod : prod;
        case (op_q)
            OP_MUL:             result = prod_s[XLEN-1:0];
            OP_DIV, OP_DIVU:    result = neg_res ? -lo_n : lo_n;
            OP_REM, OP_REMU:    result = neg_rem ? -hi_n : hi_n;
            default:            result = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    assign last = step && (cnt == CNT_W'(XLEN - 1));

    // Operand load on start, one iteration per busy cycle; reset abandons any run.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_ADD;
            opnd    <= '0;
            hi      <= '0;
            lo      <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            op_q    <= op;
            hi      <= '0;
            cnt     <= '0;
            neg_rem <= sa;
            if (is_div(op)) begin
                lo      <= mag_a;
                opnd    <= mag_b;
                // A zero divisor must leave the all-ones quotient unnegated.
                neg_res <= (sa ^ sb) && (b != '0);
            end else begin
                lo      <= mag_b;
                opnd    <= mag_a;
                neg_res <= sa ^ sb;
            end
        end else if (step) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with valid/ready handshake, single-cycle ops and flags
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            less_than,
    output logic            less_than_u
);

    localparam int SHW = $clog2(XLEN);

    ctrl_state_t     state;
    ctrl_state_t     state_n;
    logic            accept;
    logic            md_last;
    logic [XLEN-1:0] md_result;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    logic            lt_s;
    logic            lt_u;
    logic            cmp_op;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign shamt     = b[SHW-1:0];
    assign lt_s      = $signed(a) < $signed(b);
    assign lt_u      = a < b;
    assign cmp_op    = alu_op inside {OP_ADD, OP_SUB, OP_SLT, OP_SLTU};

    seq_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_muldiv(alu_op)),
        .step   (state == ST_BUSY),
        .op     (alu_op),
        .a      (a),
        .b      (b),
        .last   (md_last),
        .result (md_result)
    );

    // Single-cycle result; unassigned codes produce zero.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:   alu_res = a + b;
            OP_SUB:   alu_res = a - b;
            OP_SLL:   alu_res = a << shamt;
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
            OP_XOR:   alu_res = a ^ b;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = $signed(a) >>> shamt;
            OP_OR:    alu_res = a | b;
            OP_AND:   alu_res = a & b;
            OP_PASSB: alu_res = b;
            OP_ADDB:  alu_res = a + b;
            default:  alu_res = '0;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Controller next state: requests outside IDLE are never accepted.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = is_muldiv(alu_op) ? ST_BUSY : ST_DONE;
            ST_BUSY: if (md_last) state_n = ST_DONE;
            ST_DONE: if (out_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Result and flags load only when an op completes, so they hold through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            result      <= '0;
            zero        <= 1'b0;
            less_than   <= 1'b0;
            less_than_u <= 1'b0;
        end else if (accept && !is_muldiv(alu_op)) begin
            result      <= alu_res;
            zero        <= (alu_res == '0);
            less_than   <= cmp_op ? lt_s : alu_res[XLEN-1];
            less_than_u <= cmp_op ? lt_u : 1'b0;
        end else if (md_last) begin
            result      <= md_result;
            zero        <= (md_result == '0);
            less_than   <= md_result[XLEN-1];
            less_than_u <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized and directed self-checking bench for seq_alu at XLEN 32 and 8
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    alu_op_t     alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        less_than;
    logic        less_than_u;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    alu_op_t     alu_op8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  result8;
    logic        zero8;
    logic        less_than8;
    logic        less_than_u8;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_op      (alu_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .less_than   (less_than),
        .less_than_u (less_than_u)
    );

    seq_alu #(.XLEN(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a           (a8),
        .b           (b8),
        .alu_op      (alu_op8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .result      (result8),
        .zero        (zero8),
        .less_than   (less_than8),
        .less_than_u (less_than_u8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V arithmetic via 64-bit integers. Returns {ltu, lt, zero, result}.
    function automatic logic [34:0] model(input alu_op_t op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0]     r;
        logic [63:0]     p;
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic            lt;
        logic            ltu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        p  = '0;
        case (op)
            OP_ADD, OP_ADDB: r = x + y;
            OP_SUB:    r = x - y;
            OP_SLL:    r = x << y[4:0];
            OP_SLT:    r = (sx < sy) ? 32'd1 : 32'd0;
            OP_SLTU:   r = (x < y) ? 32'd1 : 32'd0;
            OP_XOR:    r = x ^ y;
            OP_SRL:    r = x >> y[4:0];
            OP_SRA:    r = 32'($signed(x) >>> y[4:0]);
            OP_OR:     r = x | y;
            OP_AND:    r = x & y;
            OP_PASSB:  r = y;
            OP_MUL:    begin p = ux * uy;             r = p[31:0];  end
            OP_MULH:   begin p = sx * sy;             r = p[63:32]; end
            OP_MULHSU: begin p = sx * longint'(uy);   r = p[63:32]; end
            OP_MULHU:  begin p = ux * uy;             r = p[63:32]; end
            OP_DIV:    r = (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
            OP_DIVU:   r = (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
            OP_REM:    r = (y == 0) ? x : 32'(sx % sy);
            OP_REMU:   r = (y == 0) ? x : 32'(ux % uy);
            default:   r = 32'd0;
        endcase
        if (op inside {OP_ADD, OP_SUB, OP_SLT, OP_SLTU}) begin
            lt  = sx < sy;
            ltu = x < y;
        end else begin
            lt  = r[31];
            ltu = 1'b0;
        end
        return {ltu, lt, (r == 32'd0), r};
    endfunction

    function automatic int model_latency(input alu_op_t op);
        return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                           OP_DIV, OP_DIVU, OP_REM, OP_REMU}) ? 33 : 1;
    endfunction

    // Issue one request, measure latency, check result/flags, hold for `hold` cycles, consume.
    task automatic run(input alu_op_t op, input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [34:0] e;
        int          lat;
        int          waited;
        string       nm;
        e  = model(op, x, y);
        nm = $sformatf("op%0d", int'(op));
        @(negedge clk);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        alu_op   = op;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check({nm, " in_ready"}, in_ready, 1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 100);
        check({nm, " latency"}, lat, model_latency(op));
        check({nm, " result"}, result, e[31:0]);
        check({nm, " zero"}, zero, e[32]);
        check({nm, " less_than"}, less_than, e[33]);
        check({nm, " less_than_u"}, less_than_u, e[34]);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            alu_op   = OP_SUB;
            @(negedge clk);
            check({nm, " hold out_valid"}, out_valid, 1);
            check({nm, " hold result"}, result, e[31:0]);
            check({nm, " hold flags"}, {less_than_u, less_than, zero}, e[34:32]);
            check({nm, " hold in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, " consumed out_valid"}, out_valid, 0);
        check({nm, " consumed in_ready"}, in_ready, 1);
    endtask

    task automatic run8(input alu_op_t op, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp, input int exp_lat);
        int    lat;
        string nm;
        nm = $sformatf("x8 op%0d", int'(op));
        @(negedge clk);
        in_valid8 = 1'b1;
        a8        = x;
        b8        = y;
        alu_op8   = op;
        check({nm, " in_ready"}, in_ready8, 1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid8 = 1'b0;
            lat++;
        end while (!out_valid8 && lat < 100);
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " result"}, result8, exp);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check({nm, " consumed in_ready"}, in_ready8, 1);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    alu_op_t ops [22];

    // Directed corner cases, reset abandonment, randomized sweep, then the narrow instance.
    initial begin
        int  lat;
        logic any_valid;
        ops = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                OP_OR, OP_AND, OP_PASSB, OP_ADDB, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                OP_DIV, OP_DIVU, OP_REM, OP_REMU, alu_op_t'(5'd13), alu_op_t'(5'd27)};
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        alu_op     = OP_ADD;
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        a8         = '0;
        b8         = '0;
        alu_op8    = OP_ADD;
        repeat (3) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset flags", {less_than_u, less_than, zero}, 0);
        rst = 1'b0;
        check("post-reset in_ready", in_ready, 1);

        run(OP_ADD, 32'd5, 32'd7, 0);
        run(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run(OP_DIVU, 32'd9, 32'd0, 0);
        run(OP_REMU, 32'd9, 32'd0, 0);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd0, 0);
        run(OP_REM, 32'hFFFF_FFF9, 32'd0, 0);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1);
        run(OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
        run(OP_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
        run(OP_SRA, 32'h8000_0000, 32'h0000_003F, 5);
        run(OP_SUB, 32'd3, 32'd3, 0);
        run(alu_op_t'(5'd14), 32'hDEAD_BEEF, 32'd1, 2);

        // Reset ten cycles into a divide: no result may appear.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'd100;
        b        = 32'd7;
        alu_op   = OP_DIV;
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        check("abort result", result, 0);
        any_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            any_valid |= out_valid;
        end
        check("abort no late result", any_valid, 0);
        run(OP_ADD, 32'd1, 32'd1, 0);

        for (int i = 0; i < 250; i++) begin
            run(ops[$urandom_range(0, 21)], rnd_val(), rnd_val(), $urandom_range(0, 2));
        end

        run8(OP_MUL, 8'h0F, 8'h11, 8'hFF, 9);
        run8(OP_SLL, 8'h01, 8'h0F, 8'h80, 1);
        run8(OP_DIV, 8'h80, 8'hFF, 8'h80, 9);
        run8(OP_MULHU, 8'hFF, 8'hFF, 8'hFE, 9);
        run8(OP_REMU, 8'd9, 8'd0, 8'd9, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
